// File: rtl/cache_request_queue_pkg.sv
// cache_types_pkg: shared types, constants and helpers for the cache request
// queue.
//   CacheRequestType_t      - request kind, packed as a 32-bit int field
//   TAG_POISON/WORD_POISON  - fill values for fields a read does not carry
//   cache_request_width()   - width of the flat packed request
//   cache_request_pack()    - packs the fields MSB first into a wide vector;
//                             the caller truncates the result to REQ_WIDTH
package cache_types_pkg;

  typedef enum int {
    CACHE_READ      = 0,
    CACHE_WRITE     = 1,
    CACHE_DRAM_FILL = 2
  } CacheRequestType_t;

  localparam logic [21:0] TAG_POISON  = 22'h277BAD;
  localparam logic [31:0] WORD_POISON = 32'h0BADF00D;

  // Upper bound on the packed request; the top checks REQ_WIDTH against it.
  localparam int PACK_MAX = 1024;
  typedef logic [PACK_MAX-1:0] PackVec_t;

  function automatic int cache_request_width(input int indexWidth,
                                             input int offsetWidth,
                                             input int tagWidth,
                                             input int wordWidth,
                                             input int cacheSets);
    return indexWidth + offsetWidth + tagWidth + wordWidth + 32 + 1 +
           wordWidth / 8 + $clog2(cacheSets);
  endfunction

  // Shift the accumulator left by width and append the low width bits of field.
  function automatic PackVec_t packField(input PackVec_t acc,
                                         input PackVec_t field,
                                         input int width);
    PackVec_t mask;
    mask = ~({PACK_MAX{1'b1}} << width);
    return (acc << width) | (field & mask);
  endfunction

  function automatic PackVec_t cache_request_pack(input PackVec_t index,
                                                  input PackVec_t blockOffset,
                                                  input PackVec_t tag,
                                                  input PackVec_t writeData,
                                                  input logic [31:0] requestType,
                                                  input logic isValid,
                                                  input PackVec_t writeEnable,
                                                  input PackVec_t writeSet,
                                                  input int indexWidth,
                                                  input int offsetWidth,
                                                  input int tagWidth,
                                                  input int wordWidth,
                                                  input int setWidth);
    PackVec_t acc;
    acc = '0;
    acc = packField(acc, index, indexWidth);
    acc = packField(acc, blockOffset, offsetWidth);
    acc = packField(acc, tag, tagWidth);
    acc = packField(acc, writeData, wordWidth);
    acc = packField(acc, PackVec_t'(requestType), 32);
    acc = packField(acc, PackVec_t'(isValid), 1);
    acc = packField(acc, writeEnable, wordWidth / 8);
    acc = packField(acc, writeSet, setWidth);
    return acc;
  endfunction

endpackage

// File: rtl/cache_request_queue_if.sv
// cache_request_queue_if: request-side and cache-side handshake bundle.
//   in_*       - typed request from the load/store unit or fill engine
//   out_*      - packed request toward the cache array front end
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; valid never waits on ready, and a valid producer holds its
// payload stable until the transfer.
//   slave  - the queue's view
//   master - the producer/consumer (bench) view
interface cache_request_queue_if #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = 22,
  parameter int WORD_WIDTH   = 32,
  parameter int CACHE_SETS   = 8
) ();
  import cache_types_pkg::*;

  localparam int REQ_WIDTH = cache_request_width(INDEX_WIDTH, OFFSET_WIDTH,
                                                 TAG_WIDTH, WORD_WIDTH, CACHE_SETS);
  localparam int SET_WIDTH = $clog2(CACHE_SETS);

  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_type;
  logic [INDEX_WIDTH-1:0]    in_index;
  logic [OFFSET_WIDTH-1:0]   in_offset;
  logic [TAG_WIDTH-1:0]      in_tag;
  logic [WORD_WIDTH-1:0]     in_data;
  logic [WORD_WIDTH/8-1:0]   in_we;
  logic [SET_WIDTH-1:0]      in_set;
  logic                      out_valid;
  logic                      out_ready;
  logic [REQ_WIDTH-1:0]      out_request;

  modport slave (
    input  in_valid, in_type, in_index, in_offset, in_tag, in_data, in_we, in_set,
    input  out_ready,
    output in_ready, out_valid, out_request
  );

  modport master (
    output in_valid, in_type, in_index, in_offset, in_tag, in_data, in_we, in_set,
    output out_ready,
    input  in_ready, out_valid, out_request
  );

endinterface

// File: rtl/cache_request_queue_fifo.sv
// cache_request_fifo: generic DEPTH x WIDTH synchronous FIFO.
//   clock, reset      - posedge clock, async active-high reset
//   flush             - synchronous clear of all entries (wins over a push)
//   wrValid/wrReady   - push handshake; ready also when a pop frees a slot
//   rdValid/rdReady   - pop handshake on the head entry
//   rdData            - head entry straight from storage, zero when empty
//   occupancy         - entries held, 0..DEPTH
module cache_request_fifo #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wrValid,
  output logic                     wrReady,
  input  logic [WIDTH-1:0]         wrData,
  output logic                     rdValid,
  input  logic                     rdReady,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wrPtr;
  logic [PTR_WIDTH-1:0] rdPtr;
  logic [PTR_WIDTH:0]   count;
  logic                 push;
  logic                 pop;

  assign rdValid   = (count != '0);
  assign pop       = rdValid && rdReady;
  // A pop in the same cycle frees the slot a full queue needs; flush keeps
  // the producer unblocked since whatever it offers is discarded anyway.
  assign wrReady   = flush || (count < FULL_COUNT) || pop;
  assign push      = wrValid && wrReady && !flush;
  assign rdData    = rdValid ? mem[rdPtr] : '0;
  assign occupancy = count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/cache_request_queue.sv
// cache_request_queue: normalises typed cache requests, packs them into the
// flat cache-request layout and buffers them in a DEPTH-entry FIFO.
//   clock, reset   - posedge clock, async active-high reset
//   bus (slave)    - in_* request port and out_* packed-request port
//   flush          - discard all queued entries at the next edge
//   occupancy      - entries held
//   illegal_pulse  - one-cycle pulse after an accepted in_type==3 request
module cache_request_queue
  import cache_types_pkg::*;
#(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = 22,
  parameter int WORD_WIDTH   = 32,
  parameter int CACHE_SETS   = 8,
  parameter int DEPTH        = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  cache_request_queue_if.slave   bus,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   illegal_pulse
);
  localparam int SET_WIDTH = $clog2(CACHE_SETS);
  localparam int WE_WIDTH  = WORD_WIDTH / 8;
  localparam int REQ_WIDTH = INDEX_WIDTH + OFFSET_WIDTH + TAG_WIDTH + WORD_WIDTH +
                             32 + 1 + WE_WIDTH + SET_WIDTH;

  if (REQ_WIDTH != cache_request_width(INDEX_WIDTH, OFFSET_WIDTH, TAG_WIDTH,
                                       WORD_WIDTH, CACHE_SETS)) begin : gWidthCheck
    $error("cache_request_queue: REQ_WIDTH disagrees with cache_request_width()");
  end
  if (REQ_WIDTH > PACK_MAX) begin : gPackCheck
    $error("cache_request_queue: REQ_WIDTH exceeds PACK_MAX");
  end
  if ((WORD_WIDTH % 8) != 0) begin : gWordCheck
    $error("cache_request_queue: WORD_WIDTH must be a multiple of 8");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gDepthCheck
    $error("cache_request_queue: DEPTH must be a power of two, at least 2");
  end

  logic [31:0]             reqTypeBits;
  logic                    isIllegal;
  logic [TAG_WIDTH-1:0]    normTag;
  logic [WORD_WIDTH-1:0]   normData;
  logic [WE_WIDTH-1:0]     normWe;
  logic [SET_WIDTH-1:0]    normSet;
  logic [REQ_WIDTH-1:0]    packedReq;

  always_comb begin
    reqTypeBits = 32'(bus.in_type);
    isIllegal   = (bus.in_type == 2'd3);
    normTag     = bus.in_tag;
    normData    = bus.in_data;
    normWe      = bus.in_we;
    normSet     = bus.in_set;
    case (reqTypeBits)
      CACHE_READ: begin
        // Reads carry no tag, data or way; poison makes stray use visible.
        normTag  = TAG_WIDTH'(TAG_POISON);
        normData = WORD_WIDTH'(WORD_POISON);
        normWe   = '0;
        normSet  = '0;
      end
      CACHE_WRITE: begin
        normWe = bus.in_we;
      end
      CACHE_DRAM_FILL: begin
        // A fill always writes the whole word.
        normWe = '1;
      end
      default: begin
        normWe = bus.in_we;
      end
    endcase

    packedReq = REQ_WIDTH'(cache_request_pack(
      PackVec_t'(bus.in_index), PackVec_t'(bus.in_offset), PackVec_t'(normTag),
      PackVec_t'(normData), reqTypeBits, 1'b1, PackVec_t'(normWe),
      PackVec_t'(normSet), INDEX_WIDTH, OFFSET_WIDTH, TAG_WIDTH, WORD_WIDTH,
      SET_WIDTH));
  end

  // Illegal requests still see a normal in_ready and are consumed, but never
  // reach the FIFO.
  cache_request_fifo #(
    .WIDTH(REQ_WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .wrValid  (bus.in_valid && !isIllegal),
    .wrReady  (bus.in_ready),
    .wrData   (packedReq),
    .rdValid  (bus.out_valid),
    .rdReady  (bus.out_ready),
    .rdData   (bus.out_request),
    .occupancy(occupancy)
  );

  // A request swallowed by flush is discarded silently, even if illegal.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_pulse <= 1'b0;
    end else begin
      illegal_pulse <= bus.in_valid && bus.in_ready && isIllegal && !flush;
    end
  end

endmodule

// File: doc/cache_request_queue.md
Name: cache_request_queue

Overview:
- Parametrised successor to the single-shot cache request builder.
- Accepts typed requests (read, write, DRAM fill) on a valid/ready port.
- Normalises each request: poison fields, forced isValid, write-enable rules.
- Packs each request into the flat cache-request layout and buffers it in a DEPTH-entry FIFO.
- Drains the FIFO to the cache pipeline over a second valid/ready port.
- Sits between the load/store unit or fill engine and the cache array front end.

Parameters:
- INDEX_WIDTH, 6, set-index bits.
- OFFSET_WIDTH, 4, block-offset bits.
- TAG_WIDTH, 22, physical-tag bits.
- WORD_WIDTH, 32, data word bits; must be a multiple of 8.
- CACHE_SETS, 8, ways; writeSet width = $clog2(CACHE_SETS).
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  Single clock; all state rises on posedge.
- reset  in  1  Asynchronous, active-high reset.
- in_valid  in  1  Request offered.
- in_ready  out  1  Request accepted this cycle when in_valid is also high.
- in_type  in  2  0=CACHE_READ, 1=CACHE_WRITE, 2=CACHE_DRAM_FILL, 3=illegal.
- in_index  in  INDEX_WIDTH  Set index.
- in_offset  in  OFFSET_WIDTH  Block offset.
- in_tag  in  TAG_WIDTH  Physical tag; ignored for reads.
- in_data  in  WORD_WIDTH  Write/fill data; ignored for reads.
- in_we  in  WORD_WIDTH/8  Byte enables; used for writes only.
- in_set  in  $clog2(CACHE_SETS)  Target way; ignored for reads.
- flush  in  1  Synchronous discard of all queued entries.
- out_valid  out  1  Head entry valid.
- out_ready  in  1  Consumer takes head.
- out_request  out  REQ_WIDTH  Packed request, MSB first: index, blockOffset, tag, writeData, requestType (32-bit int enum), isValid, writeEnable, writeSet.
- occupancy  out  $clog2(DEPTH)+1  Entries held.
- illegal_pulse  out  1  One-cycle pulse for a dropped illegal request.

Behaviour:
- REQ_WIDTH = INDEX+OFFSET+TAG+WORD+32+1+WORD/8+$clog2(SETS); default 104. The block elaborates an error if REQ_WIDTH mismatches the package width function.
- Reset (async, active-high), all outputs:
  - out_valid=0, occupancy=0, illegal_pulse=0, out_request=0.
  - FIFO pointers are 0.
  - in_ready=1 (it is combinational from state).
- Normalisation on enqueue:
  - READ: tag = TAG_POISON, writeData = WORD_POISON, writeEnable=0, writeSet=0. Poison constants are 22'h277BAD and 32'hBADF00D, truncated or zero-extended to the parameter widths.
  - WRITE: all fields passed through.
  - DRAM_FILL: writeEnable forced to all ones.
  - isValid is always 1.
- Handshakes:
  - Enqueue when in_valid && in_ready.
  - Dequeue when out_valid && out_ready.
  - in_ready = (occupancy<DEPTH) || (out_valid && out_ready). Simultaneous enqueue and dequeue at full is allowed and leaves occupancy unchanged.
  - out_valid = (occupancy!=0); out_request is the registered head entry.
  - Latency from accept to out_valid is 1 cycle. There is no bypass.
  - out_request is held stable while out_valid && !out_ready.
- Illegal type (in_type==3):
  - in_ready behaves as normal.
  - The request is consumed but not stored.
  - illegal_pulse=1 in the following cycle.
- Pointers wrap modulo DEPTH. occupancy never exceeds DEPTH or underflows.
- flush:
  - Takes effect at the next edge: occupancy and pointers go to 0 and out_valid goes to 0.
  - flush dominates a same-cycle enqueue; that request is discarded and reports no illegal_pulse.
  - in_ready stays 1 during flush.
- Reset mid-transfer discards all entries immediately (async).

Decomposition:
- Package cache_types_pkg holds:
  - CacheRequestType_t (int enum) and the poison constants.
  - A width function cache_request_width(...).
  - The parametrised packing function.
- Sub-module cache_request_fifo: a generic DEPTH x REQ_WIDTH synchronous FIFO with flush and occupancy.
- The top module contains only normalisation, packing and the illegal-type logic.

Test Plan:
- Read, index=6'h2A, offset=4'h5, out_ready=1 -> one cycle later out_valid=1 and out_request = {6'h2A, 4'h5, 22'h277BAD, 32'h0BADF00D, 32'd0, 1, 4'h0, 3'd0}.
- Write, tag=22'h1, data=32'hDEADBEEF, we=4'b0101, set=3 -> fields pass through, requestType=32'd1.
- Fill with we=4'b0000 -> emitted writeEnable=4'hF, requestType=32'd2.
- Hold out_ready=0 and offer 5 requests at DEPTH=4 -> 4 accepted, in_ready=0 on the 5th, occupancy=4. Then out_ready=1 with in_valid=1 -> in_ready=1 and occupancy stays 4. Drain order is FIFO.
- in_type=3 while the queue holds 2 entries -> occupancy stays 2, illegal_pulse high for exactly 1 cycle.
- 3 entries queued, flush asserted together with a valid read -> next cycle occupancy=0 and out_valid=0. Assert reset mid-drain -> outputs are 0 immediately, without waiting for a clock edge.
